// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter that shares the single axi_master_interface command path between two requesters.
// It holds each command until completion, packs 32-bit read beats into a 128-bit line, and returns done/err per requester.
module axi_master_arbiter #(
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req0_write,
    input  logic [7:0]   req0_addr,
    input  logic [127:0] req0_wdata,
    input  logic [2:0]   req0_burst,
    output logic         req0_ack,
    output logic         req0_done,
    output logic         req0_err,
    output logic [127:0] req0_rdata,
    input  logic         req1_valid,
    input  logic         req1_write,
    input  logic [7:0]   req1_addr,
    input  logic [127:0] req1_wdata,
    input  logic [2:0]   req1_burst,
    output logic         req1_ack,
    output logic         req1_done,
    output logic         req1_err,
    output logic [127:0] req1_rdata,
    output logic         write,
    output logic         read,
    output logic [7:0]   addr_wr,
    output logic [7:0]   addr_rd,
    output logic [127:0] data_wr,
    output logic [2:0]   w_burst,
    output logic [2:0]   r_burst,
    input  logic         done,
    input  logic         done_r,
    input  logic [31:0]  data_rd,
    input  logic         rd_beat
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            ptr_q, ptr_d, gnt_q, gnt_d;
    logic            cmd_wr_q, cmd_wr_d;
    logic [7:0]      addr_q, addr_d;
    logic [127:0]    wdata_q, wdata_d;
    logic [2:0]      burst_q, burst_d;
    logic            err_q, err_d;
    logic [2:0]      beat_q, beat_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [127:0]    rbuf_q, rbuf_d;
    logic            write_q, write_d, read_q, read_d;
    logic [7:0]      addr_wr_q, addr_wr_d, addr_rd_q, addr_rd_d;
    logic [127:0]    data_wr_q, data_wr_d;
    logic [2:0]      w_burst_q, w_burst_d, r_burst_q, r_burst_d;
    logic [1:0]      ack_q, ack_d, done_q, done_d, rerr_q, rerr_d;
    logic [127:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic            sel_c, cmp_c, bad_burst_c, drop_c;

    // Pointer-indexed requester wins if valid, otherwise the other one.
    assign sel_c       = ptr_q ? req1_valid : ~req0_valid;
    assign cmp_c       = cmd_wr_q ? done : done_r;
    assign bad_burst_c = (burst_q == 3'd0) || (32'(burst_q) > MAX_BURST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cmd_wr_d  = cmd_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        burst_d   = burst_q;
        err_d     = err_q;
        beat_d    = beat_q;
        to_d      = to_q;
        rbuf_d    = rbuf_q;
        write_d   = write_q;
        read_d    = read_q;
        addr_wr_d = addr_wr_q;
        addr_rd_d = addr_rd_q;
        data_wr_d = data_wr_q;
        w_burst_d = w_burst_q;
        r_burst_d = r_burst_q;
        ack_d     = 2'b00;
        done_d    = 2'b00;
        rerr_d    = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        drop_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d    = sel_c;
                    cmd_wr_d = sel_c ? req1_write : req0_write;
                    addr_d   = sel_c ? req1_addr  : req0_addr;
                    wdata_d  = sel_c ? req1_wdata : req0_wdata;
                    burst_d  = sel_c ? req1_burst : req0_burst;
                    ack_d    = sel_c ? 2'b10 : 2'b01;
                    err_d    = 1'b0;
                    beat_d   = 3'd0;
                    to_d     = '0;
                    rbuf_d   = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_burst_c) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    if (cmd_wr_q) begin
                        write_d   = 1'b1;
                        addr_wr_d = addr_q;
                        data_wr_d = wdata_q;
                        w_burst_d = burst_q;
                    end else begin
                        read_d    = 1'b1;
                        addr_rd_d = addr_q;
                        r_burst_d = burst_q;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Beats past the requested count are dropped.
                if (!cmd_wr_q && rd_beat && (beat_q < burst_q)) begin
                    rbuf_d[{beat_q[1:0], 5'd0} +: 32] = data_rd;
                    beat_d = beat_q + 3'd1;
                end
                to_d = to_q + TO_W'(1);
                if (cmp_c) begin
                    drop_c  = 1'b1;
                    state_d = S_RELEASE;
                end else if (to_d == TO_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    drop_c  = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Level-style completion must fall before we can respond.
                if (!cmp_c) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done_d = gnt_q ? 2'b10 : 2'b01;
                rerr_d = gnt_q ? {err_q, 1'b0} : {1'b0, err_q};
                if (gnt_q) begin
                    rdata1_d = rbuf_q;
                end else begin
                    rdata0_d = rbuf_q;
                end
                ptr_d   = ~gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (drop_c) begin
            write_d   = 1'b0;
            read_d    = 1'b0;
            addr_wr_d = 8'd0;
            addr_rd_d = 8'd0;
            data_wr_d = '0;
            w_burst_d = 3'd0;
            r_burst_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            cmd_wr_q  <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= '0;
            burst_q   <= 3'd0;
            err_q     <= 1'b0;
            beat_q    <= 3'd0;
            to_q      <= '0;
            rbuf_q    <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            addr_wr_q <= 8'd0;
            addr_rd_q <= 8'd0;
            data_wr_q <= '0;
            w_burst_q <= 3'd0;
            r_burst_q <= 3'd0;
            ack_q     <= 2'b00;
            done_q    <= 2'b00;
            rerr_q    <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cmd_wr_q  <= cmd_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
            to_q      <= to_d;
            rbuf_q    <= rbuf_d;
            write_q   <= write_d;
            read_q    <= read_d;
            addr_wr_q <= addr_wr_d;
            addr_rd_q <= addr_rd_d;
            data_wr_q <= data_wr_d;
            w_burst_q <= w_burst_d;
            r_burst_q <= r_burst_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            rerr_q    <= rerr_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign req0_ack   = ack_q[0];
    assign req1_ack   = ack_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = rerr_q[0];
    assign req1_err   = rerr_q[1];
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign write      = write_q;
    assign read       = read_q;
    assign addr_wr    = addr_wr_q;
    assign addr_rd    = addr_rd_q;
    assign data_wr    = data_wr_q;
    assign w_burst    = w_burst_q;
    assign r_burst    = r_burst_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter with a small behavioural master and word memory.
module tb_axi_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0]   req0_addr, req1_addr;
    logic [127:0] req0_wdata, req1_wdata;
    logic [2:0]   req0_burst, req1_burst;
    logic         req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
    logic [127:0] req0_rdata, req1_rdata;
    logic         write, read;
    logic [7:0]   addr_wr, addr_rd;
    logic [127:0] data_wr;
    logic [2:0]   w_burst, r_burst;
    logic         done = 1'b0, done_r = 1'b0, rd_beat = 1'b0;
    logic [31:0]  data_rd = 32'd0;

    axi_master_arbiter #(.MAX_BURST(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_burst(req0_burst), .req0_ack(req0_ack),
        .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_burst(req1_burst), .req1_ack(req1_ack),
        .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
        .write(write), .read(read), .addr_wr(addr_wr), .addr_rd(addr_rd),
        .data_wr(data_wr), .w_burst(w_burst), .r_burst(r_burst),
        .done(done), .done_r(done_r), .data_rd(data_rd), .rd_beat(rd_beat)
    );

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int beats_seen = 0;
    logic [31:0] mem [0:255];

    int           m_ph = 0;
    logic [7:0]   m_addr;
    int           m_n, m_k;
    logic [127:0] m_dat;
    bit           m_stall = 1'b0;

    // Behavioural master: writes land in mem then done pulses; reads stream beats then done_r.
    always @(negedge clk) begin
        if (reset) begin
            m_ph = 0; done = 1'b0; done_r = 1'b0; rd_beat = 1'b0; data_rd = 32'd0;
        end else begin
            done = 1'b0; done_r = 1'b0; rd_beat = 1'b0;
            if (write && read) overlap++;
            case (m_ph)
                0: begin
                    if (write) begin
                        m_addr = addr_wr; m_n = int'(w_burst); m_dat = data_wr; m_ph = 1;
                    end else if (read) begin
                        m_addr = addr_rd; m_n = int'(r_burst); m_k = 0; m_ph = 3;
                    end
                end
                1: begin
                    for (int k = 0; k < m_n; k++) mem[m_addr + 8'(k)] = m_dat[32*k +: 32];
                    done = 1'b1;
                    m_ph = 2;
                end
                2: if (!write && !read) m_ph = 0;
                3: begin
                    if (m_k < m_n) begin
                        rd_beat = 1'b1; data_rd = mem[m_addr + 8'(m_k)]; m_k++; beats_seen++;
                    end else begin
                        done_r = !m_stall;
                        m_ph = 2;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit which, input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            got = which ? req1_done : req0_done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got, prev_w, fin;
        int hi, n, nd;
        int order [4];
        logic [2:0] bad [2];
        logic [127:0] line;

        reset = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = '0; req0_burst = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = '0; req1_burst = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | 32'(i);
        repeat (3) tick();
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_ack0", req0_ack, 0);
        check("rst_done1", req1_done, 0);
        check("rst_data_wr", data_wr, 0);
        check("rst_rdata0", req0_rdata, 0);
        reset = 1'b0;
        tick();

        // req0 write burst 4 at 0x04
        line = 128'habcd1010efef11112222222233333333;
        req0_valid = 1; req0_write = 1; req0_addr = 8'h04; req0_burst = 3'd4; req0_wdata = line;
        tick();
        check("wr_ack0", req0_ack, 1);
        check("wr_cmd_early", write, 0);
        req0_valid = 0; req0_wdata = '0;
        tick();
        check("wr_write", write, 1);
        check("wr_addr", addr_wr, 8'h04);
        check("wr_data", data_wr, line);
        check("wr_wburst", w_burst, 3'd4);
        check("wr_read", read, 0);
        check("wr_ack_pulse", req0_ack, 0);
        got = 0; prev_w = 0;
        for (int i = 0; i < 20 && !got; i++) begin prev_w = write; tick(); got = done; end
        check("wr_done_seen", got, 1);
        check("wr_write_held", prev_w, 1);
        check("wr_write_drop", write, 0);
        tick();
        check("wr_done_early", req0_done, 0);
        tick();
        check("wr_done", req0_done, 1);
        check("wr_err", req0_err, 0);
        check("wr_rdata", req0_rdata, 0);
        tick();
        check("wr_done_pulse", req0_done, 0);
        for (int k = 0; k < 4; k++) check("wr_mem", mem[4 + k], line[32*k +: 32]);

        // req1 read back the same line
        beats_seen = 0;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h04; req1_burst = 3'd4;
        tick();
        check("rd_ack1", req1_ack, 1);
        req1_valid = 0;
        tick();
        check("rd_read", read, 1);
        check("rd_addr", addr_rd, 8'h04);
        check("rd_rburst", r_burst, 3'd4);
        check("rd_write", write, 0);
        check("rd_wburst", w_burst, 0);
        check("rd_data_wr", data_wr, 0);
        wait_done(1'b1, 30, got);
        check("rd_done_seen", got, 1);
        check("rd_rdata", req1_rdata, line);
        check("rd_err", req1_err, 0);
        check("rd_beats", beats_seen, 4);

        // contention from reset: strict alternation
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req0_valid = 1; req0_write = 1; req0_addr = 8'h10; req0_burst = 3'd2; req0_wdata = 128'h1234;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h04; req1_burst = 3'd4;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            tick();
            if (req0_ack) begin order[n] = 0; n++; end
            else if (req1_ack) begin order[n] = 1; n++; end
        end
        req0_valid = 0; req1_valid = 0;
        check("cont_nacks", n, 4);
        check("cont_order0", order[0], 0);
        check("cont_order1", order[1], 1);
        check("cont_order2", order[2], 0);
        check("cont_order3", order[3], 1);
        wait_done(1'b1, 30, got);
        check("cont_drain", got, 1);
        check("cont_overlap", overlap, 0);

        // illegal bursts 0 and 5 bypass the master
        bad[0] = 3'd0; bad[1] = 3'd5;
        for (int b = 0; b < 2; b++) begin
            req1_valid = 1; req1_write = 1'(b); req1_addr = 8'h30; req1_burst = bad[b];
            tick();
            check("bad_ack", req1_ack, 1);
            req1_valid = 0;
            tick();
            check("bad_done_early", req1_done, 0);
            check("bad_cmd", {write, read}, 2'b00);
            tick();
            check("bad_done", req1_done, 1);
            check("bad_err", req1_err, 1);
            check("bad_cmd2", {write, read}, 2'b00);
            tick();
            check("bad_done_pulse", req1_done, 0);
        end

        // read timeout: done_r withheld
        m_stall = 1;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h00; req1_burst = 3'd2;
        tick();
        check("to_ack", req1_ack, 1);
        req1_valid = 0;
        hi = 0; fin = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            tick();
            if (read) hi++;
            else if (hi > 0) fin = 1;
        end
        check("to_read_cycles", hi, 8);
        wait_done(1'b1, 10, got);
        check("to_done_seen", got, 1);
        check("to_err", req1_err, 1);
        check("to_rdata", req1_rdata, {64'h0, 32'hA5000001, 32'hA5000000});
        m_stall = 0;
        tick();

        // move pointer to 1, then reset in the middle of a req1 write
        req0_valid = 1; req0_write = 1; req0_burst = 3'd0;
        tick();
        check("ptr_ack0", req0_ack, 1);
        req0_valid = 0;
        repeat (3) tick();
        req1_valid = 1; req1_write = 1; req1_addr = 8'h20; req1_burst = 3'd1; req1_wdata = 128'h55;
        tick();
        check("mid_ack1", req1_ack, 1);
        req1_valid = 0;
        tick();
        check("mid_write", write, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_write", write, 0);
        check("mid_rst_data", data_wr, 0);
        check("mid_rst_wburst", w_burst, 0);
        check("mid_rst_addr", addr_wr, 0);
        tick(); tick();
        reset = 1'b0;
        nd = 0;
        repeat (6) begin tick(); if (req0_done || req1_done) nd++; end
        check("mid_no_done", nd, 0);
        req0_valid = 1; req0_write = 1; req0_addr = 8'h40; req0_burst = 3'd1; req0_wdata = 128'h77;
        req1_valid = 1; req1_write = 1; req1_addr = 8'h50; req1_burst = 3'd1; req1_wdata = 128'h88;
        tick();
        check("post_ack0", req0_ack, 1);
        check("post_ack1", req1_ack, 0);
        req0_valid = 0; req1_valid = 0;
        wait_done(1'b0, 30, got);
        check("post_done0", got, 1);
        check("post_mem", mem[8'h40], 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
